otp_access_arbiter: RTL

OTP_ACCESS_ARBITER -- requirements
Module: otp_access_arbiter

---
 rtl/otp_pkg.sv | 24 ++
 rtl/otp_rr_picker.sv | 33 +++
 rtl/otp_access_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/otp_pkg.sv
// Shared definitions for the OTP access arbiter: controller mode codes,
// FSM state encoding and the ISSUE phase length.
package otp_pkg;

    localparam logic [1:0] MODE_READ  = 2'b00;
    localparam logic [1:0] MODE_WRITE = 2'b01;
    localparam logic [1:0] MODE_IDLE  = 2'b10;

    // The array controller double-samples its inputs, so a command is held this long.
    localparam int ISSUE_CYC = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } otp_state_t;

    function automatic logic [1:0] mode_for(input logic is_write);
        return is_write ? MODE_WRITE : MODE_READ;
    endfunction

endpackage

// File: rtl/otp_rr_picker.sv
// Combinational round-robin picker: lowest requesting index at or above
// rr_ptr, wrapping modulo NREQ; returns both one-hot and binary winner.
module otp_rr_picker #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  winner_oh,
    output logic [IDX_W-1:0] winner_idx,
    output logic             any_req
);

    logic found;

    always_comb begin
        winner_oh  = '0;
        winner_idx = '0;
        found      = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && (j == (int'(rr_ptr) + i) % NREQ) && req[j]) begin
                    found         = 1'b1;
                    winner_oh[j]  = 1'b1;
                    winner_idx    = IDX_W'(j);
                end
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/otp_access_arbiter.sv
// Round-robin arbiter granting requesters exclusive access to an OTP array
// controller. Optional WAIT watchdog enabled by defining OTP_ARB_TIMEOUT_EN.
module otp_access_arbiter
    import otp_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int A           = 2,
    parameter int B           = 2,
    parameter int ADDR_WIDTH  = $clog2(B),
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            req_wr,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_col,
    input  logic [NREQ*A-1:0]          req_data,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            done,
    output logic [NREQ-1:0]            err,
    output logic [A-1:0]               rdata,
    output logic                       busy,
    output logic [1:0]                 ctl_mode,
    output logic [ADDR_WIDTH-1:0]      ctl_column,
    output logic [A-1:0]               ctl_data_in,
    input  logic                       ctl_done,
    input  logic [A-1:0]               ctl_data_out
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

    if (NREQ < 1 || ADDR_WIDTH < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("otp_access_arbiter: NREQ, ADDR_WIDTH and TIMEOUT_CYC must be >= 1");
    end

    otp_state_t            state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      win_idx;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] col_q;
    logic [A-1:0]          data_q;
    logic [1:0]            issue_cnt;
`ifdef OTP_ARB_TIMEOUT_EN
    logic [WD_W-1:0]       watchdog;
`endif

    logic [NREQ-1:0]       pick_oh;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_col;
    logic [A-1:0]          sel_data;
    logic                  col_bad;
    logic [IDX_W-1:0]      rr_next;

    otp_rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req        (req),
        .rr_ptr     (rr_ptr),
        .winner_oh  (pick_oh),
        .winner_idx (pick_idx),
        .any_req    (pick_any)
    );

    assign sel_wr   = req_wr[pick_idx];
    assign sel_col  = req_col[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_data = req_data[pick_idx*A +: A];
    // Widen before comparing so a column field that cannot reach B still elaborates cleanly.
    assign col_bad  = 32'(col_q) >= 32'(B);
    assign rr_next  = (32'(win_idx) == NREQ - 1) ? '0 : win_idx + IDX_W'(1);
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            gnt         <= '0;
            done        <= '0;
            err         <= '0;
            rdata       <= '0;
            ctl_mode    <= MODE_IDLE;
            ctl_column  <= '0;
            ctl_data_in <= '0;
            rr_ptr      <= '0;
            win_idx     <= '0;
            wr_q        <= 1'b0;
            col_q       <= '0;
            data_q      <= '0;
            issue_cnt   <= '0;
`ifdef OTP_ARB_TIMEOUT_EN
            watchdog    <= '0;
`endif
        end else begin
            done <= '0;
            err  <= '0;
            case (state)
                ST_IDLE: begin
                    // Grant is registered here so it is already visible during ARB.
                    if (pick_any) begin
                        state   <= ST_ARB;
                        gnt     <= pick_oh;
                        win_idx <= pick_idx;
                        wr_q    <= sel_wr;
                        col_q   <= sel_col;
                        data_q  <= sel_data;
                    end
                end
                ST_ARB: begin
                    if (!pick_any) begin
                        state <= ST_IDLE;
                        gnt   <= '0;
                    end else if (col_bad) begin
                        state <= ST_RESP;
                        err   <= gnt;
                    end else begin
                        state       <= ST_ISSUE;
                        ctl_mode    <= mode_for(wr_q);
                        ctl_column  <= col_q;
                        ctl_data_in <= data_q;
                        issue_cnt   <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (issue_cnt == 2'(ISSUE_CYC - 1)) begin
                        state <= ST_WAIT;
`ifdef OTP_ARB_TIMEOUT_EN
                        watchdog <= '0;
`endif
                    end else begin
                        issue_cnt <= issue_cnt + 2'd1;
                    end
                end
                ST_WAIT: begin
                    if (ctl_done) begin
                        state    <= ST_RESP;
                        done     <= gnt;
                        ctl_mode <= MODE_IDLE;
                        if (!wr_q) begin
                            rdata <= ctl_data_out;
                        end
                    end
`ifdef OTP_ARB_TIMEOUT_EN
                    else if (watchdog == WD_W'(TIMEOUT_CYC - 1)) begin
                        state    <= ST_RESP;
                        err      <= gnt;
                        ctl_mode <= MODE_IDLE;
                    end else begin
                        watchdog <= watchdog + WD_W'(1);
                    end
`endif
                end
                ST_RESP: begin
                    state  <= ST_IDLE;
                    gnt    <= '0;
                    rr_ptr <= rr_next;
                end
                default: begin
                    state    <= ST_IDLE;
                    gnt      <= '0;
                    ctl_mode <= MODE_IDLE;
                end
            endcase
        end
    end

endmodule
